// File: rtl/if_id_pkg.sv
// Shared types and constants for the fetch-to-decode buffer.
package if_id_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_PC_W   = 32;

    // Instruction presented to decode whenever the buffer is empty.
    localparam logic [DEF_DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

    // One fetched packet at the default widths.
    typedef struct packed {
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_DATA_W-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/if_id_fifo_mem.sv
// Packet storage for the fetch-to-decode buffer: DEPTH registers, one
// write port, asynchronous read. Ordering and occupancy live in the parent.
module if_id_fifo_mem
    import if_id_pkg::*;
#(
    parameter type pkt_t = fetch_pkt_t,
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  pkt_t             wr_data,
    input  logic [PTR_W-1:0] rd_ptr,
    output pkt_t             rd_data
);

    pkt_t mem [DEPTH];

    // Capture the incoming packet into the slot at the write pointer.
    // NOTE: storage has no reset; stale entries are invisible because the
    // parent masks the read data with its occupancy count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/if_id_buffer.sv
// In-order decoupling queue between instruction fetch and decode.
// if_ready comes from registered occupancy only, so decode stalls never
// form a combinational path back into fetch. flush empties the queue.
// Optional: define IF_ID_PERF_CNT_EN to add stall_cnt / flush_cnt outputs.
module if_id_buffer
    import if_id_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  PC_W   = DEF_PC_W,
    parameter int  DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [PC_W-1:0]   if_pc,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [PC_W-1:0]   id_pc,
    output logic [CNT_W-1:0]  occupancy
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] instr;
    } pkt_t;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    pkt_t             wr_pkt;
    pkt_t             head_pkt;

    // Handshakes; a redirect suppresses both sides in the same cycle.
    assign if_ready  = (count < CNT_W'(DEPTH));
    assign id_valid  = (count != '0);
    assign push      = if_valid & if_ready & ~flush;
    assign pop       = id_valid & id_ready & ~flush;
    assign occupancy = count;
    assign wr_pkt    = '{pc: if_pc, instr: if_instr};

    if_id_fifo_mem #(
        .pkt_t (pkt_t),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_ptr  (wr_ptr),
        .wr_data (wr_pkt),
        .rd_ptr  (rd_ptr),
        .rd_data (head_pkt)
    );

    // Pointer and occupancy bookkeeping; flush returns everything to empty.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Present the head packet, or a NOP bubble when nothing is held.
    // NOTE: outputs get defaults first so no path through this block
    // leaves them unassigned (which would infer a latch).
    always_comb begin
        id_instr = DATA_W'(NOP_INSTR);
        id_pc    = '0;
        if (id_valid) begin
            id_instr = head_pkt.instr;
            id_pc    = head_pkt.pc;
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    // Saturating count of cycles where decode holds off a valid packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (id_valid && !id_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Saturating count of redirects that actually discarded packets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (flush && id_valid && flush_cnt != 16'hFFFF) begin
            flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer (DEPTH=2). A queue-based model of
// the buffer's contents supplies every expected value.
module tb_if_id_buffer;
    import if_id_pkg::*;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst_n;
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_instr;
    logic [31:0]       if_pc;
    logic              flush;
    logic              id_valid;
    logic              id_ready;
    logic [31:0]       id_instr;
    logic [31:0]       id_pc;
    logic [CNT_W-1:0]  occupancy;
`ifdef IF_ID_PERF_CNT_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       flush_cnt;
`endif

    int checks;
    int failures;

    // Model of the queued packets, head at index 0.
    fetch_pkt_t mq[$];

    if_id_buffer #(
        .DATA_W (32),
        .PC_W   (32),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_instr  (id_instr),
        .id_pc     (id_pc),
        .occupancy (occupancy)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock and apply the buffer rules to the model.
    task automatic tick();
        bit         push;
        bit         pop;
        fetch_pkt_t p;
        push    = if_valid && (mq.size() < DEPTH) && !flush;
        pop     = (mq.size() != 0) && id_ready && !flush;
        p.pc    = if_pc;
        p.instr = if_instr;
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (pop)  mq.delete(0);
            if (push) mq.push_back(p);
        end
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (id_valid !== 1'b0 || occupancy !== '0 || id_instr !== 32'h0 || id_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_initial: valid=%b occ=%0d instr=%h pc=%h required 0/0/0/0",
                     id_valid, occupancy, id_instr, id_pc);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        id_ready = 1'b0;
        if_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if_pc    = $urandom;
            if_instr = $urandom;
            tick();
        end
        if_valid = 1'b0;
        checks++;
        if (occupancy !== CNT_W'(2) || id_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_prefill: occ=%0d valid=%b required 2/1", occupancy, id_valid);
        end
        #2 rst_n = 1'b0;
        mq.delete();
        #1;
        checks++;
        if (id_valid !== 1'b0 || occupancy !== '0 || id_instr !== 32'h0 || id_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_async: valid=%b occ=%0d instr=%h pc=%h required 0/0/0/0",
                     id_valid, occupancy, id_instr, id_pc);
        end
        checks++;
        if (if_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_if_ready: got %b required 1", if_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming();
        logic [31:0] instrs [3];
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_valid  = 1'b1;
            if_pc     = 32'(4 * i);
            instrs[i] = $urandom;
            if_instr  = instrs[i];
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(4 * i) || id_instr !== instrs[i]) begin
                failures++;
                $display("FAIL stream_head%0d: valid=%b pc=%h instr=%h required 1/%h/%h",
                         i, id_valid, id_pc, id_instr, 32'(4 * i), instrs[i]);
            end
            checks++;
            if (occupancy !== CNT_W'(1)) begin
                failures++;
                $display("FAIL stream_occ%0d: got %0d required 1", i, occupancy);
            end
        end
        if_valid = 1'b0;
        tick();
        checks++;
        if (occupancy !== '0 || id_valid !== 1'b0 || id_instr !== NOP_INSTR) begin
            failures++;
            $display("FAIL stream_drain: occ=%0d valid=%b instr=%h required 0/0/%h",
                     occupancy, id_valid, id_instr, NOP_INSTR);
        end
    endtask

    task automatic test_backpressure();
        id_ready = 1'b0;
        if_valid = 1'b1;
        if_instr = 32'h11; if_pc = 32'h11;
        tick();
        checks++;
        if (occupancy !== CNT_W'(1) || if_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_one: occ=%0d if_ready=%b required 1/1", occupancy, if_ready);
        end
        if_instr = 32'h22; if_pc = 32'h22;
        tick();
        checks++;
        if (occupancy !== CNT_W'(2) || if_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full: occ=%0d if_ready=%b required 2/0", occupancy, if_ready);
        end
        if_instr = 32'h33; if_pc = 32'h33;
        tick();
        tick();
        checks++;
        if (occupancy !== CNT_W'(2) || if_ready !== 1'b0 || id_instr !== 32'h11) begin
            failures++;
            $display("FAIL bp_hold: occ=%0d if_ready=%b head=%h required 2/0/11",
                     occupancy, if_ready, id_instr);
        end
        id_ready = 1'b1;
        tick();
        checks++;
        if (if_ready !== 1'b1 || id_instr !== 32'h22 || occupancy !== CNT_W'(1)) begin
            failures++;
            $display("FAIL bp_release: if_ready=%b head=%h occ=%0d required 1/22/1",
                     if_ready, id_instr, occupancy);
        end
        tick();
        if_valid = 1'b0;
        checks++;
        if (id_instr !== 32'h33 || id_pc !== 32'h33 || occupancy !== CNT_W'(1)) begin
            failures++;
            $display("FAIL bp_third: head=%h pc=%h occ=%0d required 33/33/1",
                     id_instr, id_pc, occupancy);
        end
        tick();
        checks++;
        if (occupancy !== '0 || id_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: occ=%0d valid=%b required 0/0", occupancy, id_valid);
        end
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        if_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if_pc    = $urandom;
            if_instr = $urandom;
            tick();
        end
        if_pc    = 32'h0000_DEAD;
        if_instr = 32'hBAD0_BAD0;
        flush    = 1'b1;
        id_ready = 1'b1;
        tick();
        flush    = 1'b0;
        if_valid = 1'b0;
        checks++;
        if (id_valid !== 1'b0 || occupancy !== '0 || id_pc !== 32'h0 || if_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_empty: valid=%b occ=%0d pc=%h if_ready=%b required 0/0/0/1",
                     id_valid, occupancy, id_pc, if_ready);
        end
        tick();
        checks++;
        if (id_valid !== 1'b0 || occupancy !== '0) begin
            failures++;
            $display("FAIL flush_no_push: valid=%b occ=%0d required 0/0", id_valid, occupancy);
        end
        if_valid = 1'b1;
        if_pc    = 32'h0000_1000;
        if_instr = 32'h1234_5678;
        tick();
        if_valid = 1'b0;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0000_1000 || id_instr !== 32'h1234_5678) begin
            failures++;
            $display("FAIL flush_refill: valid=%b pc=%h instr=%h required 1/1000/12345678",
                     id_valid, id_pc, id_instr);
        end
        tick();
    endtask

    task automatic test_wrap();
        fetch_pkt_t src [10];
        fetch_pkt_t got [$];
        fetch_pkt_t p;
        int         idx;
        int         cyc;
        idx = 0;
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            src[i].pc    = $urandom;
            src[i].instr = $urandom;
        end
        while (got.size() < 10 && cyc < 300) begin
            if_valid = (idx < 10) && ($urandom_range(0, 3) != 0);
            if_pc    = src[(idx < 10) ? idx : 9].pc;
            if_instr = src[(idx < 10) ? idx : 9].instr;
            id_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (id_valid !== (mq.size() != 0) || occupancy !== CNT_W'(mq.size()) ||
                if_ready !== (mq.size() < DEPTH)) begin
                failures++;
                $display("FAIL wrap_ctrl c%0d: valid=%b occ=%0d if_ready=%b model_size=%0d",
                         cyc, id_valid, occupancy, if_ready, mq.size());
            end
            if (mq.size() != 0) begin
                checks++;
                if (id_pc !== mq[0].pc || id_instr !== mq[0].instr) begin
                    failures++;
                    $display("FAIL wrap_head c%0d: pc=%h instr=%h required %h/%h",
                             cyc, id_pc, id_instr, mq[0].pc, mq[0].instr);
                end
            end
            if (id_valid === 1'b1 && id_ready) begin
                p.pc    = id_pc;
                p.instr = id_instr;
                got.push_back(p);
            end
            if (if_valid && mq.size() < DEPTH) idx++;
            tick();
            cyc++;
        end
        if_valid = 1'b0;
        id_ready = 1'b0;
        checks++;
        if (got.size() != 10) begin
            failures++;
            $display("FAIL wrap_count: delivered %0d required 10", got.size());
        end
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== src[i]) begin
                failures++;
                $display("FAIL wrap_order%0d: got %h required %h", i, got[i], src[i]);
            end
        end
    endtask

`ifdef IF_ID_PERF_CNT_EN
    task automatic test_perf();
        rst_n = 1'b0;
        mq.delete();
        #2;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            failures++;
            $display("FAIL perf_reset: stall=%0d flush=%0d required 0/0", stall_cnt, flush_cnt);
        end
        id_ready = 1'b1;
        if_valid = 1'b1;
        if_pc = 32'h40; if_instr = 32'h4040;
        tick();
        if_valid = 1'b0;
        id_ready = 1'b0;
        repeat (5) tick();
        id_ready = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        if_valid = 1'b1;
        tick();
        if_valid = 1'b0;
        flush    = 1'b1;
        tick();
        tick();
        flush    = 1'b0;
        tick();
        checks++;
        if (stall_cnt !== 16'd5) begin
            failures++;
            $display("FAIL perf_stall: got %0d required 5", stall_cnt);
        end
        checks++;
        if (flush_cnt !== 16'd2) begin
            failures++;
            $display("FAIL perf_flush: got %0d required 2", flush_cnt);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        flush    = 1'b0;
        id_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_wrap();
`ifdef IF_ID_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
